router_out_ctrl: RTL and testbench
==================================

ROUTER_OUT_CTRL -- requirements
Module: router_out_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 30, consecutive stalled cycles before soft reset (legal 2..255).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 fifo_empty  input  1  FIFO empty flag.
REQ-005 fifo_data  input  8  FIFO read data, valid one cycle after fifo_rd_en.
REQ-006 fifo_rd_en  output  1  FIFO read strobe, combinational.
REQ-007 out_data  output  8  registered byte to downstream.
REQ-008 out_valid  output  1  out_data valid.
REQ-009 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-010 out_sop  output  1  out_data is a header byte.
REQ-011 out_eop  output  1  out_data is a parity byte.
REQ-012 soft_reset  output  1  one-cycle registered pulse on timeout, drives FIFO soft_reset.
REQ-013 parity_err  output  1  one-cycle registered pulse on parity mismatch.
REQ-014 pkt_count  output  8  completed packets delivered.

Function
REQ-015 Packet format SHALL be: header (bits [7:2] payload length L, 0..63; bits [1:0] destination), L payload bytes, one parity byte.
REQ-016 Transfer SHALL occur in a cycle where out_valid && out_ready.
REQ-017 fifo_rd_en SHALL equal !fifo_empty && !rd_pend && (!out_valid || out_ready) && !soft_reset.
REQ-018 rd_pend SHALL be 1 in the cycle after fifo_rd_en is 1, otherwise 0.
REQ-019 When rd_pend = 1, fifo_data SHALL load into out_data and out_valid SHALL be 1 next cycle.
REQ-020 out_valid SHALL clear after a transfer unless a new byte loads in the same cycle.
REQ-021 Peak throughput SHALL be one byte per two cycles.
REQ-022 out_data and out_valid SHALL be held stable while out_valid && !out_ready.
REQ-023 FSM states SHALL be HDR and BODY; reset state is HDR.
REQ-024 HDR, byte loaded: out_sop = 1, remaining = L + 1 (7-bit), parity accumulator = byte, next state BODY.
REQ-025 BODY, byte loaded: remaining decrements.
REQ-026 BODY, byte loaded with remaining = 1: the byte is parity, out_eop = 1, next state HDR.
REQ-027 BODY, other byte loaded: the byte is payload and XORs into the parity accumulator.
REQ-028 L = 0: the byte after the header SHALL be parity (out_sop then out_eop).
REQ-029 out_sop and out_eop SHALL track the loaded byte and hold with out_data.
REQ-030 Parity mismatch: parity_err SHALL pulse for one cycle, in the cycle the parity byte appears on out_data; the byte is still delivered.
REQ-031 pkt_count SHALL increment on a transfer with out_eop = 1, wrapping 255 -> 0.
REQ-032 Stall counter SHALL increment each cycle out_valid && !out_ready, and clear otherwise.
REQ-033 When the stall counter reaches TIMEOUT-1 while still stalled, soft_reset SHALL be 1 next cycle.
REQ-034 In that same cycle: out_valid = 0, rd_pend = 0, FSM = HDR, stall counter = 0, parity accumulator = 0.
REQ-035 Timeout: the partial packet SHALL be discarded with no eop, pkt_count unchanged, and no parity_err.
REQ-036 A byte arriving with rd_pend in the timeout cycle SHALL be discarded.
REQ-037 Timeout and transfer in the same cycle cannot coincide, since ready clears the stall counter.

Reset
REQ-038 With resetn = 0 at a clock edge, the following SHALL reset:
  - outputs out_data = 0, out_valid = 0, out_sop = 0, out_eop = 0, soft_reset = 0, parity_err = 0, pkt_count = 0;
  - internal rd_pend = 0, FSM = HDR, remaining = 0, stall counter = 0, accumulator = 0.
REQ-039 fifo_rd_en SHALL be 0 while resetn = 0.
REQ-040 Reset SHALL override all events, including a packet in progress or a pending timeout.

Verification
REQ-041 Bench SHALL cover the following directed scenarios:
  - FIFO holds 0x08,0xAA,0x55,0xF7 with out_ready = 1 -> four bytes in order; sop on 0x08; eop on 0xF7; no parity_err; pkt_count = 1.
  - Header 0x00 then parity 0x01 -> parity_err pulses once while 0x01 is on out_data; pkt_count = 1.
  - out_ready = 0 for 29 cycles with out_valid = 1, then 1 -> no soft_reset; byte delivered unchanged.
  - out_ready held 0 for 30 cycles mid-packet -> soft_reset pulses once; out_valid = 0; next byte read is treated as a header.
  - resetn = 0 mid-BODY, then a new packet -> all outputs 0; new packet delivered with sop on its header.
  - 256 back-to-back L = 0 packets with correct parity -> pkt_count wraps to 0; fifo_rd_en never asserted on consecutive cycles.

Source files
------------

// File: rtl/router_out_ctrl_if.sv
// Router output-side bus bundle.
// Groups the FIFO read port, the downstream valid/ready byte stream and the
// status outputs of router_out_ctrl. Clock and reset stay outside.
//   master : the controller (drives fifo_rd_en and all out_* / status signals)
//   slave  : the FIFO + downstream environment
interface router_out_ctrl_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sop;
    logic       out_eop;
    logic       soft_reset;
    logic       parity_err;
    logic [7:0] pkt_count;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_rd_en, out_data, out_valid, out_sop, out_eop,
               soft_reset, parity_err, pkt_count
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_sop, out_eop,
               soft_reset, parity_err, pkt_count
    );
endinterface

// File: rtl/router_out_ctrl.sv
// Router output controller.
// Reads bytes from the output FIFO, frames them as packets
// (header / L payload bytes / parity byte), presents them downstream on a
// registered valid/ready stream, checks packet parity and soft-resets the
// FIFO when downstream stalls for TIMEOUT consecutive cycles.
// Ports:
//   clock  : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : router_out_ctrl_if.master (FIFO read port, output stream,
//            soft_reset / parity_err pulses, pkt_count)
module router_out_ctrl #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic                clock,
    input  logic                resetn,
    router_out_ctrl_if.master   bus
);

    localparam int unsigned DW = 8;   // data byte width
    localparam int unsigned RW = 7;   // remaining-byte counter (L+1 <= 64)
    localparam int unsigned SW = 8;   // stall counter (TIMEOUT <= 255)

    typedef enum logic {
        S_HDR  = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RW-1:0]   r_remaining;
    logic [RW-1:0]   w_remaining_nxt;
    logic [DW-1:0]   r_acc;
    logic [DW-1:0]   w_acc_nxt;
    logic            r_sop;
    logic            w_sop_nxt;
    logic            r_eop;
    logic            w_eop_nxt;
    logic            w_perr_nxt;
    logic            r_perr;
    logic            r_rd_pend;
    logic [DW-1:0]   r_out_data;
    logic            r_out_valid;
    logic            r_soft_reset;
    logic [DW-1:0]   r_pkt_count;
    logic [SW-1:0]   r_stall;

    logic            w_xfer;
    logic            w_stall;
    logic            w_timeout;
    logic            w_rd_en;

    assign w_xfer    = r_out_valid &&  bus.out_ready;
    assign w_stall   = r_out_valid && !bus.out_ready;
    assign w_timeout = w_stall && (r_stall == SW'(TIMEOUT - 1));

    // Read only when the output register will be free by the time data returns;
    // rd_pend blocks back-to-back reads, giving one byte per two cycles.
    assign w_rd_en = resetn && !bus.fifo_empty && !r_rd_pend &&
                     (!r_out_valid || bus.out_ready) && !r_soft_reset;

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_sop    = r_sop;
    assign bus.out_eop    = r_eop;
    assign bus.soft_reset = r_soft_reset;
    assign bus.parity_err = r_perr;
    assign bus.pkt_count  = r_pkt_count;

    // Framing FSM: classifies each byte as it is loaded from the FIFO.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_acc_nxt       = r_acc;
        w_sop_nxt       = r_sop;
        w_eop_nxt       = r_eop;
        w_perr_nxt      = 1'b0;
        if (r_rd_pend) begin
            case (r_state)
                S_HDR: begin
                    w_sop_nxt       = 1'b1;
                    w_eop_nxt       = 1'b0;
                    w_remaining_nxt = RW'(bus.fifo_data[7:2]) + RW'(1);
                    w_acc_nxt       = bus.fifo_data;
                    w_state_nxt     = S_BODY;
                end
                S_BODY: begin
                    w_sop_nxt       = 1'b0;
                    w_remaining_nxt = r_remaining - RW'(1);
                    if (r_remaining == RW'(1)) begin
                        // Last byte of the packet is the parity byte
                        w_eop_nxt   = 1'b1;
                        w_perr_nxt  = (bus.fifo_data != r_acc);
                        w_state_nxt = S_HDR;
                    end else begin
                        w_eop_nxt = 1'b0;
                        w_acc_nxt = r_acc ^ bus.fifo_data;
                    end
                end
                default: w_state_nxt = S_HDR;
            endcase
        end
    end

    // State, datapath and status registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= S_HDR;
            r_remaining  <= '0;
            r_acc        <= '0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_perr       <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_soft_reset <= 1'b0;
            r_pkt_count  <= '0;
            r_stall      <= '0;
        end else if (w_timeout) begin
            // Downstream stuck: drop the partial packet and any byte in flight
            r_state      <= S_HDR;
            r_remaining  <= '0;
            r_acc        <= '0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_perr       <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_soft_reset <= 1'b1;
            r_stall      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_acc        <= w_acc_nxt;
            r_sop        <= w_sop_nxt;
            r_eop        <= w_eop_nxt;
            r_perr       <= w_perr_nxt;
            r_rd_pend    <= w_rd_en;
            r_soft_reset <= 1'b0;
            r_stall      <= w_stall ? (r_stall + SW'(1)) : '0;
            if (r_rd_pend) begin
                r_out_data  <= bus.fifo_data;
                r_out_valid <= 1'b1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
            if (w_xfer && r_eop) begin
                r_pkt_count <= r_pkt_count + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_router_out_ctrl.sv
// Testbench for router_out_ctrl: FIFO model, directed packets, scoreboard
// queue filled by the stimulus and drained by an independent output monitor.
module tb_router_out_ctrl;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    router_out_ctrl_if bus();

    router_out_ctrl #(.TIMEOUT(30)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          perr_cnt = 0;
    int          soft_cnt = 0;

    // FIFO model: write side fed by stimulus, read side by fifo_rd_en.
    logic [7:0]  fifo_mem [0:1023];
    int unsigned n_push = 0;
    int unsigned n_pop  = 0;

    assign bus.fifo_empty = (n_push == n_pop);

    always @(posedge clock) begin
        if (!resetn || bus.soft_reset) begin
            n_pop <= n_push;
        end else if (bus.fifo_rd_en) begin
            bus.fifo_data <= fifo_mem[n_pop[9:0]];
            n_pop         <= n_pop + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic sop, input logic eop, input bit expect_out);
        exp_t e;
        fifo_mem[n_push[9:0]] = b;
        n_push++;
        if (expect_out) begin
            e.data = b;
            e.sop  = sop;
            e.eop  = eop;
            exp_q.push_back(e);
        end
    endtask

    // Output monitor / scoreboard consumer.
    logic       prev_rd    = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clock) begin
        exp_t e;
        if (resetn) begin
            if (bus.fifo_rd_en)
                check("rd_en_back_to_back", 32'(prev_rd), 32'd0);
            if (prev_stall && !bus.soft_reset) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.soft_reset) begin
                soft_cnt <= soft_cnt + 1;
                check("soft_reset_valid", 32'(bus.out_valid), 32'd0);
            end
            if (bus.parity_err) begin
                perr_cnt <= perr_cnt + 1;
                check("perr_on_eop", 32'({bus.out_valid, bus.out_eop}), 32'h3);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %02h expected none at %0t", bus.out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(e.data));
                    check("out_sop", 32'(bus.out_sop), 32'(e.sop));
                    check("out_eop", 32'(bus.out_eop), 32'(e.eop));
                end
            end
        end
        prev_rd    <= resetn && bus.fifo_rd_en;
        prev_stall <= resetn && bus.out_valid && !bus.out_ready;
        prev_data  <= bus.out_data;
    end

    task automatic apply_reset();
        @(posedge clock);
        #1 resetn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        push_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sop_eop", 32'({bus.out_sop, bus.out_eop}), 32'd0);
        check("rst_soft_perr", 32'({bus.soft_reset, bus.parity_err}), 32'd0);
        check("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;
    endtask

    task automatic wait_drain(input int bound);
        int c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            @(negedge clock);
            c++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int perr0;
        int soft0;
        int c;
        logic [7:0] h;
        bus.out_ready = 1'b1;

        // Nominal packet L=2, correct parity
        apply_reset();
        perr0 = perr_cnt; soft0 = soft_cnt;
        @(posedge clock); #1;
        push_byte(8'h08, 1'b1, 1'b0, 1'b1);
        push_byte(8'hAA, 1'b0, 1'b0, 1'b1);
        push_byte(8'h55, 1'b0, 1'b0, 1'b1);
        push_byte(8'hF7, 1'b0, 1'b1, 1'b1);
        wait_drain(100);
        check("s1_pkt_count", 32'(bus.pkt_count), 32'd1);
        check("s1_perr", 32'(perr_cnt - perr0), 32'd0);
        check("s1_soft", 32'(soft_cnt - soft0), 32'd0);

        // L=0 packet with wrong parity
        apply_reset();
        perr0 = perr_cnt;
        @(posedge clock); #1;
        push_byte(8'h00, 1'b1, 1'b0, 1'b1);
        push_byte(8'h01, 1'b0, 1'b1, 1'b1);
        wait_drain(100);
        check("s2_perr", 32'(perr_cnt - perr0), 32'd1);
        check("s2_pkt_count", 32'(bus.pkt_count), 32'd1);

        // 29-cycle stall: below timeout
        apply_reset();
        soft0 = soft_cnt; perr0 = perr_cnt;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        push_byte(8'h04, 1'b1, 1'b0, 1'b1);
        push_byte(8'h33, 1'b0, 1'b0, 1'b1);
        push_byte(8'h37, 1'b0, 1'b1, 1'b1);
        c = 0;
        while (!bus.out_valid && c < 50) begin
            @(negedge clock);
            c++;
        end
        check("s3_valid_seen", 32'(bus.out_valid), 32'd1);
        repeat (29) @(posedge clock);
        #1 bus.out_ready = 1'b1;
        wait_drain(100);
        check("s3_soft", 32'(soft_cnt - soft0), 32'd0);
        check("s3_pkt_count", 32'(bus.pkt_count), 32'd1);
        check("s3_perr", 32'(perr_cnt - perr0), 32'd0);

        // 30-cycle stall mid-packet: timeout, partial packet dropped
        apply_reset();
        soft0 = soft_cnt; perr0 = perr_cnt;
        @(posedge clock); #1;
        push_byte(8'h0C, 1'b1, 1'b0, 1'b1);
        push_byte(8'h11, 1'b0, 1'b0, 1'b1);
        wait_drain(100);
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        push_byte(8'h22, 1'b0, 1'b0, 1'b0);
        c = 0;
        while (!bus.soft_reset && c < 60) begin
            @(negedge clock);
            c++;
        end
        check("s4_soft_seen", 32'(bus.soft_reset), 32'd1);
        check("s4_pkt_during", 32'(bus.pkt_count), 32'd0);
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
        push_byte(8'h04, 1'b1, 1'b0, 1'b1);
        push_byte(8'h5A, 1'b0, 1'b0, 1'b1);
        push_byte(8'h5E, 1'b0, 1'b1, 1'b1);
        wait_drain(100);
        check("s4_soft", 32'(soft_cnt - soft0), 32'd1);
        check("s4_pkt_count", 32'(bus.pkt_count), 32'd1);
        check("s4_perr", 32'(perr_cnt - perr0), 32'd0);

        // Reset in the middle of a packet body, then a fresh packet
        apply_reset();
        @(posedge clock); #1;
        push_byte(8'h08, 1'b1, 1'b0, 1'b1);
        push_byte(8'hAA, 1'b0, 1'b0, 1'b1);
        wait_drain(100);
        apply_reset();
        @(posedge clock); #1;
        push_byte(8'h00, 1'b1, 1'b0, 1'b1);
        push_byte(8'h00, 1'b0, 1'b1, 1'b1);
        wait_drain(100);
        check("s5_pkt_count", 32'(bus.pkt_count), 32'd1);

        // 256 back-to-back L=0 packets: pkt_count wraps
        apply_reset();
        perr0 = perr_cnt;
        @(posedge clock); #1;
        for (int i = 0; i < 255; i++) begin
            h = 8'(i & 3);
            push_byte(h, 1'b1, 1'b0, 1'b1);
            push_byte(h, 1'b0, 1'b1, 1'b1);
        end
        wait_drain(2500);
        check("s6_pkt_255", 32'(bus.pkt_count), 32'd255);
        @(posedge clock); #1;
        push_byte(8'h03, 1'b1, 1'b0, 1'b1);
        push_byte(8'h03, 1'b0, 1'b1, 1'b1);
        wait_drain(100);
        check("s6_pkt_wrap", 32'(bus.pkt_count), 32'd0);
        check("s6_perr", 32'(perr_cnt - perr0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
